// File: rtl/truth_table_sequencer.sv
// Purpose: sweeps every input vector of a WIDTH-input combinational block and
//          records its output as a 2^WIDTH-bit truth table.
// Latency: start -> done is 2^WIDTH * SETTLE cycles; abort takes effect in one edge.
// Backpressure: none; start is accepted only in IDLE, and results publish with a one-cycle done pulse.
//
// Ports:
//   i_clk, i_rst_n   clock and asynchronous active-low reset
//   i_start          single-cycle sweep request (ignored while busy)
//   i_abort          cancels a running sweep; beats start when both are high in IDLE
//   o_dut_a          vector driven to the block under test (0 when idle)
//   i_dut_out        output of the block under test
//   o_busy           sweep in progress
//   o_done           one-cycle pulse when the results below update
//   o_table_out      committed truth table, bit i = output for vector i
//   o_ones_count     population count of o_table_out
//   o_is_const0/1    o_table_out is all zeros / all ones
module truth_table_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic [WIDTH-1:0]      o_dut_a,
    input  logic                  i_dut_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [(1<<WIDTH)-1:0] o_table_out,
    output logic [WIDTH:0]        o_ones_count,
    output logic                  o_is_const0,
    output logic                  o_is_const1
);
    localparam int N = 1 << WIDTH;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0]       LAST_CNT = SETTLE[3:0] - 4'd1;
    localparam logic [WIDTH-1:0] LAST_IDX = {WIDTH{1'b1}};

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_idx;
    logic [3:0]       r_cnt;
    logic [N-1:0]     r_shadow;
    logic [N-1:0]     r_table;
    logic [WIDTH:0]   r_ones;
    logic             r_const0;
    logic             r_const1;
    logic             r_done;

    logic [N-1:0]     w_final;
    logic [WIDTH:0]   w_ones;

    // The last vector is sampled on the commit edge itself, so its bit is
    // merged here rather than read back from the shadow a cycle later.
    always_comb begin
        w_final        = r_shadow;
        w_final[N-1]   = i_dut_out;
        w_ones         = '0;
        for (int i = 0; i < N; i++) begin
            w_ones = w_ones + {{WIDTH{1'b0}}, w_final[i]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_table  <= '0;
            r_ones   <= '0;
            r_const0 <= 1'b0;
            r_const1 <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_state  <= S_RUN;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_shadow <= '0;
                    end
                end
                default: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                    end else if (r_cnt != LAST_CNT) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_shadow[r_idx] <= i_dut_out;
                        r_cnt           <= '0;
                        // Final vector found by compare so idx never wraps in RUN.
                        if (r_idx != LAST_IDX) begin
                            r_idx <= r_idx + 1'b1;
                        end else begin
                            r_table  <= w_final;
                            r_ones   <= w_ones;
                            r_const0 <= (w_final == '0);
                            r_const1 <= &w_final;
                            r_done   <= 1'b1;
                            r_state  <= S_IDLE;
                            r_idx    <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign o_busy       = (r_state == S_RUN);
    assign o_dut_a      = (r_state == S_RUN) ? r_idx : '0;
    assign o_done       = r_done;
    assign o_table_out  = r_table;
    assign o_ones_count = r_ones;
    assign o_is_const0  = r_const0;
    assign o_is_const1  = r_const1;

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Default instance (WIDTH=4, SETTLE=1)
    logic        start, abort, dut_out, busy, done, c0, c1;
    logic [3:0]  dut_a;
    logic [15:0] tbl;
    logic [4:0]  ones;
    int          mode;   // 0: XOR4, 1: AND4, other: constant 0

    // SETTLE=3 instance
    logic        start3, abort3, dut_out3, busy3, done3, c03, c13;
    logic [3:0]  dut_a3;
    logic [15:0] tbl3;
    logic [4:0]  ones3;
    logic        const3;

    int checks   = 0;
    int failures = 0;

    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0:       dut_out = ^dut_a;
            1:       dut_out = &dut_a;
            default: dut_out = 1'b0;
        endcase
    end
    assign dut_out3 = const3;

    truth_table_sequencer #(.WIDTH(4), .SETTLE(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_dut_a(dut_a), .i_dut_out(dut_out), .o_busy(busy), .o_done(done),
        .o_table_out(tbl), .o_ones_count(ones), .o_is_const0(c0), .o_is_const1(c1)
    );

    truth_table_sequencer #(.WIDTH(4), .SETTLE(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_abort(abort3),
        .o_dut_a(dut_a3), .i_dut_out(dut_out3), .o_busy(busy3), .o_done(done3),
        .o_table_out(tbl3), .o_ones_count(ones3), .o_is_const0(c03), .o_is_const1(c13)
    );

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        mode = 0; const3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start  = 1'($urandom_range(0, 1));
            start3 = 1'($urandom_range(0, 1));
            mode   = int'($urandom_range(0, 1));
            const3 = 1'($urandom_range(0, 1));
            checks++;
            if ({busy, dut_a, done, tbl, ones, c0, c1} !== 29'd0) begin
                failures++;
                $display("FAIL reset_outputs: got busy=%b dut_a=%h done=%b table=%h ones=%0d c0=%b c1=%b, want all 0",
                         busy, dut_a, done, tbl, ones, c0, c1);
            end
            checks++;
            if ({busy3, dut_a3, done3, tbl3, ones3, c03, c13} !== 29'd0) begin
                failures++;
                $display("FAIL reset_outputs3: got busy=%b dut_a=%h table=%h, want all 0", busy3, dut_a3, tbl3);
            end
        end
        start = 1'b0; start3 = 1'b0; mode = 0; const3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || dut_a !== 4'd0) begin
                failures++;
                $display("FAIL reset_release: got busy=%b done=%b dut_a=%h, want 0 0 0", busy, done, dut_a);
            end
        end
    endtask

    task automatic test_xor4();
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (dut_a !== 4'(k) || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL xor_step%0d: got dut_a=%h busy=%b done=%b, want %h 1 0", k, dut_a, busy, done, 4'(k));
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tbl !== 16'h6996 || ones !== 5'd8 || c0 !== 1'b0 || c1 !== 1'b0) begin
            failures++;
            $display("FAIL xor_commit: got done=%b busy=%b table=%h ones=%0d c0=%b c1=%b, want 1 0 6996 8 0 0",
                     done, busy, tbl, ones, c0, c1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || tbl !== 16'h6996) begin
            failures++;
            $display("FAIL xor_done_pulse: got done=%b table=%h, want 0 6996", done, tbl);
        end
    endtask

    task automatic test_settle3();
        for (int pass = 0; pass < 2; pass++) begin
            const3 = (pass == 0);
            @(negedge clk); start3 = 1'b1;
            @(negedge clk); start3 = 1'b0;
            for (int k = 0; k < 48; k++) begin
                checks++;
                if (dut_a3 !== 4'(k / 3) || busy3 !== 1'b1 || done3 !== 1'b0) begin
                    failures++;
                    $display("FAIL settle3_step%0d: got dut_a=%h busy=%b done=%b, want %h 1 0",
                             k, dut_a3, busy3, done3, 4'(k / 3));
                end
                @(negedge clk);
            end
            checks++;
            if (pass == 0) begin
                if (done3 !== 1'b1 || tbl3 !== 16'hFFFF || ones3 !== 5'd16 || c13 !== 1'b1 || c03 !== 1'b0) begin
                    failures++;
                    $display("FAIL settle3_const1: got done=%b table=%h ones=%0d c0=%b c1=%b, want 1 ffff 16 0 1",
                             done3, tbl3, ones3, c03, c13);
                end
            end else begin
                if (done3 !== 1'b1 || tbl3 !== 16'h0000 || ones3 !== 5'd0 || c03 !== 1'b1 || c13 !== 1'b0) begin
                    failures++;
                    $display("FAIL settle3_const0: got done=%b table=%h ones=%0d c0=%b c1=%b, want 1 0000 0 1 0",
                             done3, tbl3, ones3, c03, c13);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic seen_done;
        mode = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 7; k++) @(negedge clk);
        checks++;
        if (dut_a !== 4'd7) begin
            failures++;
            $display("FAIL abort_pre: got dut_a=%h, want 7", dut_a);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || dut_a !== 4'd0 || done !== 1'b0 || tbl !== 16'h6996 || ones !== 5'd8) begin
            failures++;
            $display("FAIL abort_effect: got busy=%b dut_a=%h done=%b table=%h ones=%0d, want 0 0 0 6996 8",
                     busy, dut_a, done, tbl, ones);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0 || tbl !== 16'h6996) begin
            failures++;
            $display("FAIL abort_quiet: got activity=%b table=%h, want 0 6996", seen_done, tbl);
        end
    endtask

    task automatic test_start_rules();
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            start = (k == 5);
            checks++;
            if (dut_a !== 4'(k) || done !== 1'b0) begin
                failures++;
                $display("FAIL start_ignored_step%0d: got dut_a=%h done=%b, want %h 0", k, dut_a, done, 4'(k));
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || tbl !== 16'h6996) begin
            failures++;
            $display("FAIL start_ignored_done: got done=%b table=%h, want 1 6996", done, tbl);
        end
        // Restart in the done cycle with the AND4 model.
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (dut_a !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL restart_in_done: got dut_a=%h busy=%b done=%b, want 0 1 0", dut_a, busy, done);
        end
        for (int k = 1; k < 16; k++) @(negedge clk);
        checks++;
        if (dut_a !== 4'd15 || done !== 1'b0) begin
            failures++;
            $display("FAIL restart_last_vec: got dut_a=%h done=%b, want f 0", dut_a, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || tbl !== 16'h8000 || ones !== 5'd1 || c0 !== 1'b0 || c1 !== 1'b0) begin
            failures++;
            $display("FAIL and4_commit: got done=%b table=%h ones=%0d c0=%b c1=%b, want 1 8000 1 0 0",
                     done, tbl, ones, c0, c1);
        end
        // start together with abort in IDLE must not launch a sweep.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || dut_a !== 4'd0) begin
            failures++;
            $display("FAIL abort_beats_start: got busy=%b dut_a=%h, want 0 0", busy, dut_a);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_beats_start_hold: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_midsweep();
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 10; k++) @(negedge clk);
        checks++;
        if (dut_a !== 4'd10) begin
            failures++;
            $display("FAIL midreset_pre: got dut_a=%h, want a", dut_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, dut_a, done, tbl, ones, c0, c1} !== 29'd0) begin
            failures++;
            $display("FAIL midreset_async: got busy=%b dut_a=%h done=%b table=%h ones=%0d, want all 0",
                     busy, dut_a, done, tbl, ones);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (dut_a !== 4'(k) || done !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_step%0d: got dut_a=%h done=%b, want %h 0", k, dut_a, done, 4'(k));
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || tbl !== 16'h6996 || ones !== 5'd8 || c0 !== 1'b0 || c1 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_commit: got done=%b table=%h ones=%0d, want 1 6996 8", done, tbl, ones);
        end
    endtask

    initial begin
        test_reset();
        test_xor4();
        test_settle3();
        test_abort();
        test_start_rules();
        test_reset_midsweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Sequencer that characterises a WIDTH-input, 1-output combinational block in-circuit. On a start pulse it drives every input vector 0 .. 2^WIDTH-1 onto the block in ascending order. It waits a programmable settle time per vector and samples the block's output into a 2^WIDTH-bit truth-table register. The completed table, its population count and constant-function flags are published atomically with a one-cycle done pulse. It sits beside the combinational block under test and replaces an external stimulus sweep for self-check and configuration readback.

## Interface
- WIDTH, 4, number of inputs of the block under test; legal range 1..6
- SETTLE, 1, cycles each vector is held before its output is sampled; legal range 1..15
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE
- abort  input  1  cancels a sweep in progress
- dut_a  output  WIDTH  input vector driven to the block under test
- dut_out  input  1  output of the block under test
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when a sweep completes and results update
- table_out  output  2^WIDTH  committed truth table; bit i = output for dut_a == i
- ones_count  output  WIDTH+1  number of 1 bits in table_out
- is_const0  output  1  table_out is all zeros
- is_const1  output  1  table_out is all ones

## Operation
- States: IDLE, RUN. done is a registered pulse, not a separate state.
- Reset value of every output is 0. Reset also clears idx, the settle counter cnt and the shadow table. Reset asserted mid-sweep returns to IDLE immediately, with no done pulse.
- IDLE: busy=0 and dut_a=0.
  - start=1 and abort=0 at an edge → RUN, idx=0, cnt=0, shadow table cleared.
  - abort has priority over start.
- RUN: dut_a=idx and busy=1. At each edge:
  - If cnt < SETTLE-1: cnt increments.
  - Else: shadow[idx] <= dut_out and cnt <= 0.
    - If idx < 2^WIDTH-1: idx increments.
    - Else: commit. table_out <= shadow with the final bit merged. ones_count, is_const0 and is_const1 are computed from that same committed value and registered at the same edge. done=1 for the next cycle only. State → IDLE.
- abort=1 in RUN at an edge → IDLE, busy=0, dut_a=0, no done pulse. table_out and the flags keep the previous committed values.
- start during RUN is ignored. It does not restart or queue a sweep.
- start in the cycle where done=1 is legal (the block is already in IDLE). It begins a new sweep at that edge; done still deasserts after one cycle.
- Outputs table_out, ones_count, is_const0 and is_const1 change only at commit, never partially.
- ones_count is a full popcount; for WIDTH=4 its range is 0..16 and it needs all 5 bits.
- idx is WIDTH bits wide. The final vector is detected by compare, not by wrap-around. dut_a never wraps to 0 while in RUN.

## Timing
- start sampled high at edge T → busy=1 and dut_a=0 from T.
- With SETTLE=S, vector i is driven from edge T+i·S until edge T+(i+1)·S. It is sampled at edge T+(i+1)·S, using the dut_out value present just before that edge.
- Commit happens at edge T+2^WIDTH·S. At that edge busy falls and done rises for exactly one cycle.
- Latency start→done is 2^WIDTH·S cycles: 16 cycles for the defaults.
- dut_out must be stable within S cycles of dut_a changing. Sampling is unregistered beyond the capture flop.
- abort latency is one edge. busy and dut_a are 0 after the edge at which abort is sampled.

## Test plan
- Reset: hold rst_n=0 with random start/dut_out, then release → all outputs 0, busy stays 0, no done pulse.
- XOR4 model on dut_out (default params): pulse start → dut_a steps 0..15, one per cycle. done is high exactly 16 cycles after start with table_out=16'h6996, ones_count=8, is_const0=0, is_const1=0.
- Constant models with SETTLE=3: dut_out tied 1 → done after 48 cycles, table_out=16'hFFFF, ones_count=16, is_const1=1. dut_out tied 0 → table_out=0, ones_count=0, is_const0=1. Each dut_a value is held for 3 cycles.
- Abort: after an XOR4 sweep, run an AND4 sweep (expected 16'h8000) and assert abort when dut_a=7 → busy=0 and dut_a=0 next cycle. No done pulse; table_out stays 16'h6996 and ones_count stays 8.
- Start rules: pulse start again at dut_a=5 → ignored, and done still arrives at the original cycle. Pulse start in the done cycle → a new sweep begins immediately with dut_a=0. Assert start with abort in IDLE → stays IDLE.
- Reset mid-sweep: drop rst_n at dut_a=10 → outputs 0 asynchronously. After release, a fresh start produces the correct full table.
